// File: rtl/warp_fetch_pc.sv
// warp_fetch_pc: per-warp program counters plus a one-request-per-cycle
// fetch scheduler feeding the instruction cache.
// Each warp holds a PC and an active flag. Redirects come from the SIMT
// stack (Qual1 target, Qual2 refetch) and from the decoder (Qual3 jump).
// One eligible warp is picked per cycle, and its request is registered.
// Optional feature macro: IF_RR_SCHED_EN
//   defined   -> round-robin arbitration that starts after the last granted warp
//   undefined -> fixed priority where the lowest eligible warp ID wins (no RR register)
module warp_fetch_pc #(
  parameter int NUM_WARPS = 8,
  parameter int PC_W      = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        Start_TM_IF,
  input  logic [$clog2(NUM_WARPS)-1:0] WarpID_TM_IF,
  input  logic [PC_W-1:0]             StartPC_TM_IF,
  input  logic [NUM_WARPS-1:0]        Exit_ID_IF,
  input  logic [NUM_WARPS-1:0]        UpdatePC_Qual1_SIMT_IF,
  input  logic [NUM_WARPS-1:0]        UpdatePC_Qual2_SIMT_IF,
  input  logic [NUM_WARPS-1:0]        UpdatePC_Qual3_ID_IF,
  input  logic [PC_W-1:0]             TA_ID_IF,
  input  logic [NUM_WARPS-1:0]        Stall_SIMT_IF,
  input  logic [NUM_WARPS*PC_W-1:0]   TA_SIMT_IF_Flattened,
  input  logic [NUM_WARPS-1:0]        IBFull_IB_IF,
  output logic                        FetchValid_IF_ICache,
  output logic [$clog2(NUM_WARPS)-1:0] WarpID_IF_ICache,
  output logic [PC_W-1:0]             PC_IF_ICache,
  output logic [PC_W-1:0]             PCplus4_IF_ID,
  output logic [NUM_WARPS-1:0]        ActiveWarps_IF
);

  localparam int WID_W = $clog2(NUM_WARPS);
  localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

  // Per-warp architectural state
  logic [PC_W-1:0]      pc_reg  [NUM_WARPS];
  logic [PC_W-1:0]      pc_next [NUM_WARPS];
  logic [NUM_WARPS-1:0] active_reg;
  logic [NUM_WARPS-1:0] active_next;

  // Scheduling signals
  logic [NUM_WARPS-1:0] start_onehot;
  logic [NUM_WARPS-1:0] redirect;
  logic [NUM_WARPS-1:0] eligible;
  logic [NUM_WARPS-1:0] grant_onehot;
  logic                 grant_valid;
  logic [WID_W-1:0]     grant_id;

  // Registered fetch request
  logic                 fetch_valid_reg;
  logic [WID_W-1:0]     fetch_wid_reg;
  logic [PC_W-1:0]      fetch_pc_reg;
  logic [PC_W-1:0]      fetch_pc4_reg;

  assign start_onehot = Start_TM_IF ? (NUM_WARPS'(1) << WarpID_TM_IF) : '0;
  assign redirect     = UpdatePC_Qual1_SIMT_IF | UpdatePC_Qual2_SIMT_IF | UpdatePC_Qual3_ID_IF;

  // A warp with a redirect this cycle is held back so its old PC is never issued.
  assign eligible = active_reg & ~Stall_SIMT_IF & ~IBFull_IB_IF & ~Exit_ID_IF & ~redirect;

  assign grant_onehot = grant_valid ? (NUM_WARPS'(1) << grant_id) : '0;

  // Per-warp next-state: Start beats every redirect, and redirects beat the fetch increment.
  // Exit only clears the active flag, and a Start in the same cycle overrides it.
  for (genvar gi = 0; gi < NUM_WARPS; gi++) begin : g_warp
    assign pc_next[gi] =
        start_onehot[gi]           ? StartPC_TM_IF :
        UpdatePC_Qual1_SIMT_IF[gi] ? TA_SIMT_IF_Flattened[gi*PC_W +: PC_W] :
        UpdatePC_Qual2_SIMT_IF[gi] ? pc_reg[gi] - PC_STEP :
        UpdatePC_Qual3_ID_IF[gi]   ? TA_ID_IF :
        grant_onehot[gi]           ? pc_reg[gi] + PC_STEP :
                                     pc_reg[gi];
    assign active_next[gi] = start_onehot[gi] | (active_reg[gi] & ~Exit_ID_IF[gi]);
  end

  // Per-warp PC and active flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        pc_reg[w] <= '0;
      end
      active_reg <= '0;
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        pc_reg[w] <= pc_next[w];
      end
      active_reg <= active_next;
    end
  end

`ifdef IF_RR_SCHED_EN
  logic [WID_W-1:0] rr_reg;

  // Round-robin pick: scan from the warp after the last grant, wrapping around
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    for (int i = 1; i <= NUM_WARPS; i++) begin
      if (!grant_valid && eligible[rr_reg + WID_W'(i)]) begin
        grant_valid = 1'b1;
        grant_id    = rr_reg + WID_W'(i);
      end
    end
  end

  // Last-granted pointer; the reset value of all-ones makes warp 0 first in line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_reg <= '1;
    end else if (grant_valid) begin
      rr_reg <= grant_id;
    end
  end
`else
  // Fixed-priority pick: the lowest eligible warp ID wins (scan downward so lowest is last)
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    for (int i = NUM_WARPS - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        grant_valid = 1'b1;
        grant_id    = WID_W'(i);
      end
    end
  end
`endif

  // Fetch request register; ID and PCs hold their values when nothing is granted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_valid_reg <= 1'b0;
      fetch_wid_reg   <= '0;
      fetch_pc_reg    <= '0;
      fetch_pc4_reg   <= '0;
    end else begin
      fetch_valid_reg <= grant_valid;
      if (grant_valid) begin
        fetch_wid_reg <= grant_id;
        fetch_pc_reg  <= pc_reg[grant_id];
        fetch_pc4_reg <= pc_reg[grant_id] + PC_STEP;
      end
    end
  end

  assign FetchValid_IF_ICache = fetch_valid_reg;
  assign WarpID_IF_ICache     = fetch_wid_reg;
  assign PC_IF_ICache         = fetch_pc_reg;
  assign PCplus4_IF_ID        = fetch_pc4_reg;
  assign ActiveWarps_IF       = active_reg;

endmodule

// File: tb/tb_warp_fetch_pc.sv
// Bench for warp_fetch_pc. Each cycle, the driver runs a reference model
// that is built from the per-warp rules. The model pushes the expected
// registered outputs into a queue, and a separate monitor pops one entry
// after each rising edge and compares it with the DUT outputs.
module tb_warp_fetch_pc;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  wid;
  logic [9:0]  spc;
  logic [7:0]  exitv, q1, q2, q3, stall, ibfull;
  logic [9:0]  ta_id;
  logic [79:0] ta_simt;
  logic        fv;
  logic [2:0]  fw;
  logic [9:0]  fpc, fpc4;
  logic [7:0]  act;

  always #5 clk = ~clk;

  warp_fetch_pc dut (
    .clk                    (clk),
    .rst                    (rst),
    .Start_TM_IF            (start),
    .WarpID_TM_IF           (wid),
    .StartPC_TM_IF          (spc),
    .Exit_ID_IF             (exitv),
    .UpdatePC_Qual1_SIMT_IF (q1),
    .UpdatePC_Qual2_SIMT_IF (q2),
    .UpdatePC_Qual3_ID_IF   (q3),
    .TA_ID_IF               (ta_id),
    .Stall_SIMT_IF          (stall),
    .TA_SIMT_IF_Flattened   (ta_simt),
    .IBFull_IB_IF           (ibfull),
    .FetchValid_IF_ICache   (fv),
    .WarpID_IF_ICache       (fw),
    .PC_IF_ICache           (fpc),
    .PCplus4_IF_ID          (fpc4),
    .ActiveWarps_IF         (act)
  );

  typedef struct {
    logic       v;
    logic [2:0] w;
    logic [9:0] pc;
    logic [9:0] pc4;
    logic [7:0] act;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  int m_pc[8];
  bit m_act[8];
  int m_rr;
  int l_w, l_pc, l_pc4;

  task automatic chk(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic clear_inputs();
    start = 0; wid = 0; spc = 0; exitv = 0; q1 = 0; q2 = 0; q3 = 0;
    stall = 0; ibfull = 0; ta_id = 0; ta_simt = 0;
  endtask

  task automatic model_reset();
    for (int w = 0; w < 8; w++) begin
      m_pc[w]  = 0;
      m_act[w] = 0;
    end
    m_rr = 7; l_w = 0; l_pc = 0; l_pc4 = 0;
  endtask

  // One cycle of the reference model, using the inputs currently applied
  task automatic model_step();
    bit   elig[8];
    int   g;
    exp_t e;
    g = -1;
    for (int w = 0; w < 8; w++)
      elig[w] = m_act[w] && !stall[w] && !ibfull[w] && !exitv[w] && !(q1[w] || q2[w] || q3[w]);
`ifdef IF_RR_SCHED_EN
    for (int k = 1; k <= 8; k++) begin
      if (g < 0 && elig[(m_rr + k) % 8]) g = (m_rr + k) % 8;
    end
`else
    for (int w = 0; w < 8; w++) begin
      if (g < 0 && elig[w]) g = w;
    end
`endif
    if (g >= 0) begin
      l_w = g; l_pc = m_pc[g]; l_pc4 = (m_pc[g] + 4) % 1024; m_rr = g;
    end
    for (int w = 0; w < 8; w++) begin
      if (start && wid == w) begin
        m_pc[w] = spc; m_act[w] = 1;
      end else begin
        if (q1[w])       m_pc[w] = ta_simt[10*w +: 10];
        else if (q2[w])  m_pc[w] = (m_pc[w] + 1024 - 4) % 1024;
        else if (q3[w])  m_pc[w] = ta_id;
        else if (g == w) m_pc[w] = (m_pc[w] + 4) % 1024;
        if (exitv[w]) m_act[w] = 0;
      end
    end
    e.v = (g >= 0); e.w = 3'(l_w); e.pc = 10'(l_pc); e.pc4 = 10'(l_pc4);
    for (int w = 0; w < 8; w++) e.act[w] = m_act[w];
    exp_q.push_back(e);
  endtask

  // Inputs are applied at a falling edge. The model is evaluated, then time moves to the next falling edge
  task automatic step();
    model_step();
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic launch(input int w, input int pc);
    start = 1; wid = 3'(w); spc = 10'(pc);
    step();
  endtask

  task automatic kill_all();
    exitv = 8'hFF;
    step();
  endtask

  // Monitor: after each rising edge, pop one expected entry and compare all outputs
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("fetch_valid", int'(fv), int'(e.v));
        chk("warp_id", int'(fw), int'(e.w));
        chk("fetch_pc", int'(fpc), int'(e.pc));
        chk("pc_plus4", int'(fpc4), int'(e.pc4));
        chk("active", int'(act), int'(e.act));
        if (fv) $display("REQ t=%0t warp=%0d pc=%03h pc4=%03h active=%02h", $time, fw, fpc, fpc4, act);
      end
    end
  end

  initial begin
    rst = 1'b1;
    clear_inputs();
    model_reset();
    #12;
    chk("rst_valid", int'(fv), 0);
    chk("rst_warp", int'(fw), 0);
    chk("rst_pc", int'(fpc), 0);
    chk("rst_pc4", int'(fpc4), 0);
    chk("rst_active", int'(act), 0);
    @(negedge clk);
    rst = 1'b0;

    // Single warp streaming from 0x010
    launch(0, 10'h010);
    repeat (4) step();

    // Three warps sharing fetch bandwidth
    launch(3, 10'h030);
    launch(5, 10'h050);
    repeat (8) step();
    kill_all();

    // Qual1 has priority over Qual3 when both are asserted
    launch(2, 10'h100);
    q1 = 8'h04; q3 = 8'h04; ta_simt[29:20] = 10'h2A0; ta_id = 10'h080;
    step();
    repeat (3) step();
    kill_all();

    // Qual2 wraps below zero
    launch(1, 10'h000);
    q2 = 8'h02;
    step();
    repeat (2) step();
    kill_all();

    // IBFull blocks warp 4. A Start then overrides a simultaneous Exit
    launch(4, 10'h200);
    repeat (2) step();
    repeat (3) begin
      ibfull = 8'h10;
      step();
    end
    exitv = 8'h10; start = 1; wid = 3'd4; spc = 10'h040;
    step();
    repeat (3) step();

    // PC+4 wrap at the top of the address space
    launch(6, 10'h3FC);
    repeat (3) step();

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(3) == 0) begin
        start = 1; wid = 3'($urandom_range(7)); spc = 10'($urandom);
      end
      exitv   = 8'($urandom & $urandom & $urandom & $urandom & $urandom);
      q1      = 8'($urandom & $urandom & $urandom & $urandom);
      q2      = 8'($urandom & $urandom & $urandom & $urandom);
      q3      = 8'($urandom & $urandom & $urandom & $urandom);
      stall   = 8'($urandom & $urandom & $urandom);
      ibfull  = 8'($urandom & $urandom & $urandom);
      ta_id   = 10'($urandom);
      ta_simt = {$urandom, $urandom, $urandom};
      step();
    end

    // Asynchronous reset while requests are streaming
    launch(0, 10'h020);
    launch(7, 10'h070);
    repeat (3) step();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", int'(fv), 0);
    chk("async_rst_active", int'(act), 0);
    chk("async_rst_pc", int'(fpc), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (4) step();
    launch(6, 10'h3F8);
    repeat (4) step();

    @(posedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
